// File: rtl/tdc_avg.sv
// Windowed averager for TDC samples: collects 2^LOG2N samples, then forms the
// rounded mean together with the window minimum and maximum, and presents the
// result through a hold-until-consumed output stage with a sticky overrun flag.
module tdc_avg #(
    parameter int LOG2N = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dval,
    input  logic [19:0] in_data,
    input  logic        clr,
    input  logic        rdy,
    output logic [19:0] out_data,
    output logic [19:0] out_min,
    output logic [19:0] out_max,
    output logic        o_dval,
    output logic        o_ovr
);

    localparam int AW = 20 + LOG2N;
    localparam int CW = LOG2N + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2N) - 1);
    localparam logic [AW-1:0] HALF     = AW'(1 << (LOG2N - 1));

    typedef enum logic {
        ACC,
        FIN
    } state_t;

    state_t        state_q, state_d;
    logic          dval_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [19:0]   min_q, min_d;
    logic [19:0]   max_q, max_d;
    logic          res_vld_q, res_vld_d;
    logic [19:0]   res_data_q, res_data_d;
    logic [19:0]   res_min_q, res_min_d;
    logic [19:0]   res_max_q, res_max_d;
    logic [19:0]   out_data_q, out_data_d;
    logic [19:0]   out_min_q, out_min_d;
    logic [19:0]   out_max_q, out_max_d;
    logic          o_dval_q, o_dval_d;
    logic          o_ovr_q, o_ovr_d;

    logic          sample;
    logic [AW-1:0] in_ext;
    logic [AW-1:0] acc_rnd;

    assign sample  = dval & ~dval_q;
    assign in_ext  = {{LOG2N{1'b0}}, in_data};
    assign acc_rnd = acc_q + HALF;

    // Window accumulation, FSM sequencing, result staging and output stage.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        min_d      = min_q;
        max_d      = max_q;
        res_vld_d  = 1'b0;
        res_data_d = res_data_q;
        res_min_d  = res_min_q;
        res_max_d  = res_max_q;
        out_data_d = out_data_q;
        out_min_d  = out_min_q;
        out_max_d  = out_max_q;
        o_dval_d   = o_dval_q;
        o_ovr_d    = o_ovr_q;

        if (clr) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
            min_d   = '0;
            max_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (sample) begin
                        acc_d = acc_q + in_ext;
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q == '0) begin
                            min_d = in_data;
                            max_d = in_data;
                        end else begin
                            if (in_data < min_q) min_d = in_data;
                            if (in_data > max_q) max_d = in_data;
                        end
                        if (cnt_q == CNT_LAST) state_d = FIN;
                    end
                end
                FIN: begin
                    state_d    = ACC;
                    res_vld_d  = 1'b1;
                    res_data_d = acc_rnd[AW-1:LOG2N];
                    res_min_d  = min_q;
                    res_max_d  = max_q;
                    if (sample) begin
                        acc_d = in_ext;
                        cnt_d = CW'(1);
                        min_d = in_data;
                        max_d = in_data;
                    end else begin
                        acc_d = '0;
                        cnt_d = '0;
                        min_d = '0;
                        max_d = '0;
                    end
                end
                default: state_d = ACC;
            endcase
        end

        if (res_vld_q) begin
            if (!o_dval_q || rdy) begin
                out_data_d = res_data_q;
                out_min_d  = res_min_q;
                out_max_d  = res_max_q;
                o_dval_d   = 1'b1;
            end else begin
                o_ovr_d = 1'b1;
            end
        end else if (o_dval_q && rdy) begin
            o_dval_d = 1'b0;
        end

        if (clr) o_ovr_d = 1'b0;
    end

    // State registers; dval_q resets high so a strobe held high out of reset is not a sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACC;
            dval_q     <= 1'b1;
            acc_q      <= '0;
            cnt_q      <= '0;
            min_q      <= '0;
            max_q      <= '0;
            res_vld_q  <= 1'b0;
            res_data_q <= '0;
            res_min_q  <= '0;
            res_max_q  <= '0;
            out_data_q <= '0;
            out_min_q  <= '0;
            out_max_q  <= '0;
            o_dval_q   <= 1'b0;
            o_ovr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dval_q     <= dval;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            min_q      <= min_d;
            max_q      <= max_d;
            res_vld_q  <= res_vld_d;
            res_data_q <= res_data_d;
            res_min_q  <= res_min_d;
            res_max_q  <= res_max_d;
            out_data_q <= out_data_d;
            out_min_q  <= out_min_d;
            out_max_q  <= out_max_d;
            o_dval_q   <= o_dval_d;
            o_ovr_q    <= o_ovr_d;
        end
    end

    assign out_data = out_data_q;
    assign out_min  = out_min_q;
    assign out_max  = out_max_q;
    assign o_dval   = o_dval_q;
    assign o_ovr    = o_ovr_q;

endmodule
